// File: rtl/ofdm_bin_sorter_pkg.sv
// Shared definitions for the OFDM bin sorter: FSM state encoding, null-bin
// bounds, pilot bin numbers and small per-bin helper functions.
package ofdm_bin_sorter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LTS1 = 2'd1,
    S_LTS2 = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam logic [5:0] NULL_LO_BIN = 6'd27;
  localparam logic [5:0] NULL_HI_BIN = 6'd37;

  localparam logic [5:0] PILOT_BIN_0 = 6'd7;
  localparam logic [5:0] PILOT_BIN_1 = 6'd21;
  localparam logic [5:0] PILOT_BIN_2 = 6'd43;
  localparam logic [5:0] PILOT_BIN_3 = 6'd57;

  // Bins 1..26 and 38..63 carry energy; DC and the guard band do not.
  function automatic logic is_used_bin(input logic [5:0] b);
    return (b != 6'd0) && !((b >= NULL_LO_BIN) && (b <= NULL_HI_BIN));
  endfunction

  function automatic logic is_pilot_bin(input logic [5:0] b);
    return (b == PILOT_BIN_0) || (b == PILOT_BIN_1) ||
           (b == PILOT_BIN_2) || (b == PILOT_BIN_3);
  endfunction

  // Floor of the mean of two signed 16-bit values: 17-bit sum, drop the LSB.
  function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    return sum[16:1];
  endfunction

endpackage

// File: rtl/ofdm_bin_sorter_lts_buf.sv
// 64 x 32 LTS bin buffer with combinational read and synchronous write, so the
// averaging read-modify-write completes in a single cycle per bin.
//   clock  : write clock
//   we     : write enable
//   addr   : bin address (shared by read and write)
//   wdata  : write data {I,Q}
//   rdata  : combinational read data at addr
module ofdm_bin_sorter_lts_buf (
  input  logic        clock,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem_q [64];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ofdm_bin_sorter.sv
// Sorts FFT bins of an OFDM packet: buffers the first long training symbol,
// averages it with the second and emits the averaged used bins, then passes
// data/pilot bins of up to MAX_SYMBOLS data symbols.
//   clock, reset (async active-low), enable (clock enable)
//   sample_in/sample_in_strobe   : FFT bin {I,Q} in natural order 0..63
//   long_preamble_detected       : packet start pulse
//   lts_out/lts_out_strobe       : averaged LTS used bins
//   data_out/data_out_strobe     : data/pilot used bins
//   bin_index, is_pilot, symbol_count, state : side information
module ofdm_bin_sorter
  import ofdm_bin_sorter_pkg::*;
#(
  parameter logic [15:0] MAX_SYMBOLS = 16'd1366
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  input  logic        long_preamble_detected,
  output logic [31:0] lts_out,
  output logic        lts_out_strobe,
  output logic [31:0] data_out,
  output logic        data_out_strobe,
  output logic [5:0]  bin_index,
  output logic        is_pilot,
  output logic [15:0] symbol_count,
  output logic [1:0]  state
);

  state_t      state_q, state_d;
  logic [5:0]  bin_q, bin_d;
  logic [15:0] sym_q, sym_d;
  logic [15:0] sym_out_q;
  logic [31:0] lts_out_q, lts_out_d;
  logic        lts_stb_q, lts_stb_d;
  logic [31:0] data_out_q, data_out_d;
  logic        data_stb_q, data_stb_d;
  logic [5:0]  bin_index_q, bin_index_d;
  logic        is_pilot_q, is_pilot_d;

  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  logic [31:0] avg;

  ofdm_bin_sorter_lts_buf u_lts_buf (
    .clock (clock),
    .we    (buf_we),
    .addr  (bin_q),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  assign avg = {avg16(buf_rdata[31:16], sample_in[31:16]),
                avg16(buf_rdata[15:0],  sample_in[15:0])};

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    sym_d       = sym_q;
    lts_out_d   = lts_out_q;
    lts_stb_d   = 1'b0;
    data_out_d  = data_out_q;
    data_stb_d  = 1'b0;
    bin_index_d = bin_index_q;
    is_pilot_d  = 1'b0;
    buf_we      = 1'b0;
    buf_wdata   = sample_in;

    if (enable) begin
      if (long_preamble_detected) begin
        state_d = S_LTS1;
        bin_d   = '0;
        sym_d   = '0;
      end else if (sample_in_strobe && (state_q != S_IDLE)) begin
        bin_d = bin_q + 6'd1;
        case (state_q)
          S_LTS1: buf_we = 1'b1;
          S_LTS2: begin
            buf_we    = 1'b1;
            buf_wdata = avg;
            if (is_used_bin(bin_q)) begin
              lts_out_d   = avg;
              lts_stb_d   = 1'b1;
              bin_index_d = bin_q;
            end
          end
          S_DATA: begin
            if (is_used_bin(bin_q)) begin
              data_out_d  = sample_in;
              data_stb_d  = 1'b1;
              bin_index_d = bin_q;
              is_pilot_d  = is_pilot_bin(bin_q);
            end
          end
          default: ;
        endcase
        if (bin_q == 6'd63) begin
          case (state_q)
            S_LTS1:  state_d = S_LTS2;
            S_LTS2:  state_d = S_DATA;
            S_DATA: begin
              sym_d = sym_q + 16'd1;
              if (sym_d == MAX_SYMBOLS) state_d = S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // symbol_count trails the internal counter by one cycle so that it still
  // shows the accepting symbol alongside the bin-63 output strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      sym_q       <= '0;
      sym_out_q   <= '0;
      lts_out_q   <= '0;
      lts_stb_q   <= 1'b0;
      data_out_q  <= '0;
      data_stb_q  <= 1'b0;
      bin_index_q <= '0;
      is_pilot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      sym_q       <= sym_d;
      sym_out_q   <= sym_q;
      lts_out_q   <= lts_out_d;
      lts_stb_q   <= lts_stb_d;
      data_out_q  <= data_out_d;
      data_stb_q  <= data_stb_d;
      bin_index_q <= bin_index_d;
      is_pilot_q  <= is_pilot_d;
    end
  end

  assign lts_out         = lts_out_q;
  assign lts_out_strobe  = lts_stb_q;
  assign data_out        = data_out_q;
  assign data_out_strobe = data_stb_q;
  assign bin_index       = bin_index_q;
  assign is_pilot        = is_pilot_q;
  assign symbol_count    = sym_out_q;
  assign state           = state_q;

endmodule
